// File: rtl/sensor_cond_if.sv
// Signal bundle for the sensor conditioner: raw sensor inputs toward the block,
// debounced levels, edge pulses and occupancy status back out.
interface sensor_cond_if #(
  parameter int CNT_W = 4
);
  logic             s1_raw;
  logic             s2_raw;
  logic             S1;
  logic             S2;
  logic             s1_rise;
  logic             s2_rise;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             err;

  modport master (
    output s1_raw, s2_raw,
    input  S1, S2, s1_rise, s2_rise, count, full, empty, err
  );

  modport slave (
    input  s1_raw, s2_raw,
    output S1, S2, s1_rise, s2_rise, count, full, empty, err
  );
endinterface

// File: rtl/sensor_cond.sv
// Two-channel sensor conditioner: synchronize, debounce and edge-detect the
// entry/exit sensors, then track a saturating warehouse occupancy count.
module sensor_cond #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 4
) (
  input  logic         clk,
  input  logic         rstn,
  sensor_cond_if.slave bus
);
  localparam int               DB_W    = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       raw;
  logic [1:0]       sync_p0;
  logic [1:0]       sync_p1;
  logic [1:0]       clean;
  logic [1:0]       rise;
  logic [DB_W-1:0]  db_cnt [2];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_nxt;
  logic             err_q;
  logic             err_hit;

  // Returns {overflow/underflow attempted, next count}; never wraps.
  function automatic logic [CNT_W:0] sat_step(input logic [CNT_W-1:0] cnt,
                                              input logic inc, input logic dec);
    logic [CNT_W:0] res;
    res = {1'b0, cnt};
    if (inc && !dec) begin
      if (cnt == CNT_MAX) res[CNT_W] = 1'b1;
      else                res = {1'b0, cnt + 1'b1};
    end else if (dec && !inc) begin
      if (cnt == '0) res[CNT_W] = 1'b1;
      else           res = {1'b0, cnt - 1'b1};
    end
    return res;
  endfunction

  assign raw = {bus.s2_raw, bus.s1_raw};

  // Stage p0/p1: two-flop synchronizers, the only consumers of the raw pins
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: toggle the clean level on the DB_CYCLES-th consecutive disagreeing edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clean     <= '0;
      rise      <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        rise[ch] <= 1'b0;
        if (sync_p1[ch] == clean[ch]) begin
          db_cnt[ch] <= '0;
        end else if (db_cnt[ch] == DB_LAST) begin
          clean[ch]  <= ~clean[ch];
          rise[ch]   <= ~clean[ch];
          db_cnt[ch] <= '0;
        end else begin
          db_cnt[ch] <= db_cnt[ch] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    {err_hit, count_nxt} = sat_step(count_q, rise[0], rise[1]);
  end

  // Occupancy: follows the rise pulses by one edge; err is sticky until reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      if (err_hit) err_q <= 1'b1;
    end
  end

  assign bus.S1      = clean[0];
  assign bus.S2      = clean[1];
  assign bus.s1_rise = rise[0];
  assign bus.s2_rise = rise[1];
  assign bus.count   = count_q;
  assign bus.full    = (count_q == CNT_MAX);
  assign bus.empty   = (count_q == '0);
  assign bus.err     = err_q;
endmodule

// File: tb/tb_sensor_cond.sv
// Bench for sensor_cond: table of sensor pulses with expected occupancy, a rise
// scoreboard, and hand-timed sequences for debounce latency and mid-debounce reset.
module tb_sensor_cond;
  localparam int DB  = 4;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic clk;
  logic rstn;

  sensor_cond_if #(.CNT_W(CW)) bif ();

  sensor_cond #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit r1;
    bit r2;
    int cnt;
    bit err;
  } rise_t;

  typedef struct {
    int kind;   // 1=s1, 2=s2, 3=both, 4=reset
    int width;  // raw high cycles
    int cnt;
    bit err;
  } vec_t;

  rise_t sb[$];
  rise_t pend;
  bit    chk_pend;
  int    n_vec;
  int    n_bad;
  int    m_cnt;
  bit    m_err;
  vec_t  tbl[$];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bench model of the occupancy counter; pushes the expected rise event
  task automatic expect_rise(input bit r1, input bit r2);
    rise_t r;
    if (r1 && !r2) begin
      if (m_cnt == MAX) m_err = 1'b1;
      else              m_cnt++;
    end else if (r2 && !r1) begin
      if (m_cnt == 0) m_err = 1'b1;
      else            m_cnt--;
    end
    r.r1 = r1; r.r2 = r2; r.cnt = m_cnt; r.err = m_err;
    sb.push_back(r);
  endtask

  task automatic clear_model();
    sb.delete();
    chk_pend = 1'b0;
    m_cnt    = 0;
    m_err    = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_model();
    tick();
    tick();
    rstn = 1'b1;
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_S1"}, bif.S1, 0);
    check({tag, "_S2"}, bif.S2, 0);
    check({tag, "_rise"}, {bif.s1_rise, bif.s2_rise}, 0);
    check({tag, "_count"}, bif.count, 0);
    check({tag, "_empty"}, bif.empty, 1);
    check({tag, "_full"}, bif.full, 0);
    check({tag, "_err"}, bif.err, 0);
  endtask

  task automatic pulse(input int kind, input int width);
    bif.s1_raw = kind[0];
    bif.s2_raw = kind[1];
    if (width >= DB) expect_rise(kind[0], kind[1]);
    repeat (width) tick();
    bif.s1_raw = 1'b0;
    bif.s2_raw = 1'b0;
    repeat (12) tick();
  endtask

  task automatic check_status(input string tag, input int cnt, input bit err);
    check({tag, "_count"}, bif.count, cnt);
    check({tag, "_err"}, bif.err, err);
    check({tag, "_full"}, bif.full, cnt == MAX);
    check({tag, "_empty"}, bif.empty, cnt == 0);
  endtask

  // Scoreboard: every rise must be expected; count/err checked one edge later
  always @(negedge clk) begin
    if (chk_pend) begin
      check("sb_count", bif.count, pend.cnt);
      check("sb_err", bif.err, pend.err);
      chk_pend = 1'b0;
    end
    if (rstn && (bif.s1_rise || bif.s2_rise)) begin
      if (sb.size() == 0) begin
        check("unexpected_rise", {bif.s1_rise, bif.s2_rise}, 0);
      end else begin
        pend = sb.pop_front();
        check("sb_rise_pair", {bif.s1_rise, bif.s2_rise}, {pend.r1, pend.r2});
        chk_pend = 1'b1;
      end
    end
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    clear_model();
    rstn       = 1'b0;
    bif.s1_raw = 1'b0;
    bif.s2_raw = 1'b0;
    tbl = '{
      '{2, 1, 1, 0},  // 1-cycle s2 glitch
      '{2, 3, 1, 0},  // 3-cycle s2 glitch
      '{1, 8, 2, 0},
      '{1, 8, 3, 0},
      '{3, 8, 3, 0},  // simultaneous entry/exit
      '{2, 8, 2, 0},
      '{2, 8, 1, 0},
      '{2, 8, 0, 0},
      '{2, 8, 0, 1},  // exit at empty
      '{4, 0, 0, 0}
    };

    repeat (3) tick();
    check_reset_vals("rst_init");
    rstn = 1'b1;
    tick();

    // Exact latency of a clean S1 rise
    bif.s1_raw = 1'b1;
    expect_rise(1'b1, 1'b0);
    for (int e = 1; e <= DB + 2; e++) begin
      tick();
      check($sformatf("lat_S1_e%0d", e), bif.S1, (e == DB + 2));
      check($sformatf("lat_rise_e%0d", e), bif.s1_rise, (e == DB + 2));
    end
    tick();
    check("lat_rise_off", bif.s1_rise, 0);
    check("lat_count", bif.count, 1);
    bif.s1_raw = 1'b0;
    repeat (12) tick();
    check("fall_no_rise_S1", bif.S1, 0);

    foreach (tbl[i]) begin
      if (tbl[i].kind == 4) do_reset();
      else pulse(tbl[i].kind, tbl[i].width);
      check_status($sformatf("tbl%0d", i), tbl[i].cnt, tbl[i].err);
    end
    check("glitch_S2", bif.S2, 0);

    // Reset asserted three edges into an S1 debounce
    bif.s1_raw = 1'b1;
    repeat (3) tick();
    #2 rstn = 1'b0;
    clear_model();
    #1;
    check_reset_vals("rst_mid");
    repeat (2) tick();
    #2 rstn = 1'b1;
    expect_rise(1'b1, 1'b0);
    for (int e = 1; e <= DB + 2; e++) begin
      tick();
      check($sformatf("rel_S1_e%0d", e), bif.S1, (e == DB + 2));
    end
    bif.s1_raw = 1'b0;
    repeat (12) tick();
    check_status("rel", 1, 0);

    // Fill to saturation, then one more entry
    do_reset();
    for (int i = 1; i <= MAX; i++) pulse(1, 8);
    check_status("fill", MAX, 0);
    pulse(1, 8);
    check_status("over", MAX, 1);

    repeat (4) tick();
    check("sb_leftover", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/sensor_cond.md
SENSOR_COND -- requirements
Module: sensor_cond

Interface
- REQ-001: Parameter DB_CYCLES, default 4, is the number of consecutive stable synchronized samples required before a clean level changes; legal range 2..255.
- REQ-002: Parameter CNT_W, default 4, is the width of the occupancy counter; the counter's maximum value is 2^CNT_W-1.
- REQ-003: Port clk, input, 1 bit, is the single system clock; all state updates occur on its rising edge.
- REQ-004: Port rstn, input, 1 bit, is the reset; it is asynchronous and active-low.
- REQ-005: Port s1_raw, input, 1 bit, is the raw, asynchronous entry-side presence sensor.
- REQ-006: Port s2_raw, input, 1 bit, is the raw, asynchronous exit-side presence sensor.
- REQ-007: Port S1, output, 1 bit, is the debounced entry-sensor level fed to the downstream fsm3.
- REQ-008: Port S2, output, 1 bit, is the debounced exit-sensor level fed to the downstream fsm3.
- REQ-009: Port s1_rise, output, 1 bit, is a one-cycle pulse on each 0->1 transition of S1.
- REQ-010: Port s2_rise, output, 1 bit, is a one-cycle pulse on each 0->1 transition of S2.
- REQ-011: Port count, output, CNT_W bits, is the current warehouse occupancy.
- REQ-012: Port full, output, 1 bit, is high when count equals 2^CNT_W-1.
- REQ-013: Port empty, output, 1 bit, is high when count equals 0.
- REQ-014: Port err, output, 1 bit, is a sticky flag indicating an entry at full or an exit at empty.

Function
- REQ-015: Each raw input shall pass through a two-flop synchronizer; no other logic shall sample s1_raw or s2_raw.
- REQ-016: Each channel shall have a debounce counter of ceil(log2(DB_CYCLES+1)) bits, counting edges on which the synchronized value differs from the clean output.
- REQ-017: The debounce counter shall clear to 0 on any edge where the synchronized value equals the clean output, so glitches shorter than DB_CYCLES never propagate.
- REQ-018: The clean output shall toggle, and its counter clear, on the edge where the counter would reach DB_CYCLES.
- REQ-019: A raw level held stable shall appear on S1/S2 exactly DB_CYCLES+2 rising edges after the first edge that samples it.
- REQ-020: s1_rise/s2_rise shall assert in the same cycle S1/S2 goes 0->1, last exactly one cycle, and never assert on a 1->0 transition.
- REQ-021: count shall update one edge after the rise pulse: s1_rise alone increments it, s2_rise alone decrements it, and both or neither leave it unchanged.
- REQ-022: An increment at full or a decrement at empty shall leave count unchanged (saturating, no wrap) and set err.
- REQ-023: Simultaneous s1_rise and s2_rise while full or empty shall not set err.
- REQ-024: full and empty shall be combinational decodes of the registered count.
- REQ-025: The two channels shall be fully independent; activity on one shall not alter the other's timing.

Reset
- REQ-026: While rstn is low, all synchronizer flops, debounce counters, S1, S2, s1_rise, s2_rise, count and err shall be 0; empty shall be 1 and full shall be 0.
- REQ-027: An assertion of rstn mid-debounce shall discard the partial count, and a level pending at release shall require the full DB_CYCLES+2 edges.
- REQ-028: err shall clear only on reset.

Verification (DB_CYCLES=4, CNT_W=4)
- REQ-029: s1_raw 0->1, held -> S1=1 and s1_rise=1 for one cycle exactly 6 edges later, then count=1 one edge after that.
- REQ-030: s2_raw 1-cycle and 3-cycle high glitches -> S2 stays 0, s2_rise is never asserted, and count is unchanged.
- REQ-031: 15 clean S1 pulses, then a 16th -> count=15, full=1 after the 15th; after the 16th, count stays 15 and err=1.
- REQ-032: From count=0, a clean S2 pulse -> count stays 0, empty=1, err=1.
- REQ-033: s1_raw and s2_raw rise on the same edge with count=3 -> both rise pulses occur in the same cycle, count=3, err=0.
- REQ-034: rstn pulsed low 3 edges into an S1 debounce -> all outputs at reset values; after release with s1_raw still high, S1=1 six edges later.
